// File: rtl/ads_bus_pkg.sv
// Shared definitions for the ADS serial bus master: FSM states, default
// widths and the request mode encoding.
package ads_bus_pkg;

    localparam int DEF_ADDR_WIDTH        = 16;
    localparam int DEF_DEVICE_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH        = 8;
    localparam int DEF_ACK_TIMEOUT       = 4;

    localparam logic MODE_WRITE = 1'b1;
    localparam logic MODE_READ  = 1'b0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_REQ,
        ST_DADDR,
        ST_WAIT_ACK,
        ST_SFRAME,
        ST_WDATA,
        ST_RDATA,
        ST_SPLIT,
        ST_DONE
    } state_e;

    // Widest of three field widths; sizes the shared serializer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out shifter, LSB first. A load presents bit 0 on the
// next cycle; last_o marks the cycle in which the final bit is on sout_o.
module piso_shift #(
    parameter int W  = 13,
    parameter int CW = $clog2(W + 1)
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          load_i,
    input  logic          shift_i,
    input  logic          clear_i,
    input  logic [W-1:0]  pdata_i,
    input  logic [CW-1:0] count_i,
    output logic          sout_o,
    output logic          last_o
);

    logic [W-1:0]  sh_q;
    logic [CW-1:0] cnt_q;

    // Load wins over clear; clearing keeps the serial line at 0 when idle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            sh_q  <= pdata_i;
            cnt_q <= count_i;
        end else if (clear_i) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (shift_i) begin
            sh_q  <= sh_q >> 1;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign sout_o = sh_q[0];
    assign last_o = (cnt_q == CW'(1));

endmodule

// File: rtl/master_port.sv
// ADS bus master port: takes one parallel request, arbitrates for the bus,
// serializes device address / mode / memory address / write data, and
// deserializes read data with split-transaction suspend/resume.
module master_port
    import ads_bus_pkg::*;
#(
    parameter int ADDR_WIDTH        = DEF_ADDR_WIDTH,
    parameter int DEVICE_ADDR_WIDTH = DEF_DEVICE_ADDR_WIDTH,
    parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int ACK_TIMEOUT       = DEF_ACK_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  dvalid,
    input  logic                  dmode,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic [DATA_WIDTH-1:0] dwdata,
    output logic [DATA_WIDTH-1:0] drdata,
    output logic                  dready,
    output logic                  ddone,
    output logic                  derr,
    output logic                  mbreq,
    input  logic                  mgrant,
    output logic                  mwdata,
    output logic                  mvalid,
    input  logic                  ack,
    input  logic                  mrdata,
    input  logic                  svalid,
    input  logic                  ssplit,
    input  logic                  split_grant
);

    localparam int MEM_W  = ADDR_WIDTH - DEVICE_ADDR_WIDTH;
    localparam int SF_LEN = MEM_W + 1;
    localparam int SH_W   = max3(DEVICE_ADDR_WIDTH, SF_LEN, DATA_WIDTH);
    localparam int CW     = $clog2(SH_W + 1);
    localparam int TW     = $clog2(ACK_TIMEOUT) + 1;
    localparam int RW     = $clog2(DATA_WIDTH) + 1;

    state_e                  state_q;
    logic                    mode_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rbuf_q, rbuf_d;
    logic [DATA_WIDTH-1:0]   drdata_q;
    logic [RW-1:0]           rcnt_q;
    logic [TW-1:0]           tcnt_q;
    logic                    dready_q, ddone_q, derr_q, mbreq_q, mvalid_q;

    logic                    sh_load, sh_shift, sh_clear, sh_last;
    logic [SH_W-1:0]         sh_pdata;
    logic [CW-1:0]           sh_count;

    piso_shift #(.W(SH_W), .CW(CW)) u_piso (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .load_i  (sh_load),
        .shift_i (sh_shift),
        .clear_i (sh_clear),
        .pdata_i (sh_pdata),
        .count_i (sh_count),
        .sout_o  (mwdata),
        .last_o  (sh_last)
    );

    // Serializer control: load each field one cycle before it goes out.
    always_comb begin
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_clear = 1'b0;
        sh_pdata = '0;
        sh_count = '0;
        case (state_q)
            ST_REQ: if (mgrant) begin
                sh_load = 1'b1;
                sh_pdata[DEVICE_ADDR_WIDTH-1:0] = addr_q[ADDR_WIDTH-1 -: DEVICE_ADDR_WIDTH];
                sh_count = CW'(DEVICE_ADDR_WIDTH);
            end
            ST_WAIT_ACK: if (ack) begin
                sh_load = 1'b1;
                sh_pdata[SF_LEN-1:0] = {addr_q[MEM_W-1:0], mode_q};
                sh_count = CW'(SF_LEN);
            end
            ST_SFRAME: begin
                if (!sh_last) begin
                    sh_shift = 1'b1;
                end else if (mode_q == MODE_WRITE) begin
                    sh_load = 1'b1;
                    sh_pdata[DATA_WIDTH-1:0] = wdata_q;
                    sh_count = CW'(DATA_WIDTH);
                end else begin
                    sh_clear = 1'b1;
                end
            end
            ST_DADDR, ST_WDATA: begin
                if (sh_last) sh_clear = 1'b1;
                else         sh_shift = 1'b1;
            end
            default: ;
        endcase
    end

    // Read assembly: drop the incoming bit into position rcnt.
    always_comb begin
        rbuf_d = rbuf_q;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (rcnt_q == RW'(i)) rbuf_d[i] = mrdata;
        end
    end

    // Main FSM with registered handshake and bus outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            mode_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rbuf_q   <= '0;
            drdata_q <= '0;
            rcnt_q   <= '0;
            tcnt_q   <= '0;
            dready_q <= 1'b1;
            ddone_q  <= 1'b0;
            derr_q   <= 1'b0;
            mbreq_q  <= 1'b0;
            mvalid_q <= 1'b0;
        end else begin
            ddone_q <= 1'b0;
            derr_q  <= 1'b0;
            case (state_q)
                // DONE already shows dready=1, so a request there is taken too.
                ST_IDLE, ST_DONE: begin
                    state_q <= ST_IDLE;
                    if (dvalid) begin
                        mode_q   <= dmode;
                        addr_q   <= daddr;
                        wdata_q  <= dwdata;
                        dready_q <= 1'b0;
                        mbreq_q  <= 1'b1;
                        state_q  <= ST_REQ;
                    end
                end
                ST_REQ: if (mgrant) begin
                    mvalid_q <= 1'b1;
                    state_q  <= ST_DADDR;
                end
                ST_DADDR: if (sh_last) begin
                    mvalid_q <= 1'b0;
                    tcnt_q   <= '0;
                    state_q  <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (ack) begin
                        mvalid_q <= 1'b1;
                        state_q  <= ST_SFRAME;
                    end else if (tcnt_q == TW'(ACK_TIMEOUT - 1)) begin
                        ddone_q  <= 1'b1;
                        derr_q   <= 1'b1;
                        mbreq_q  <= 1'b0;
                        dready_q <= 1'b1;
                        state_q  <= ST_DONE;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                ST_SFRAME: if (sh_last) begin
                    if (mode_q == MODE_WRITE) begin
                        state_q <= ST_WDATA;
                    end else begin
                        mvalid_q <= 1'b0;
                        rcnt_q   <= '0;
                        rbuf_q   <= '0;
                        state_q  <= ST_RDATA;
                    end
                end
                ST_WDATA: if (sh_last) begin
                    mvalid_q <= 1'b0;
                    ddone_q  <= 1'b1;
                    mbreq_q  <= 1'b0;
                    dready_q <= 1'b1;
                    state_q  <= ST_DONE;
                end
                // A completing bit takes precedence over a simultaneous split.
                ST_RDATA: begin
                    if (svalid) begin
                        rbuf_q <= rbuf_d;
                        rcnt_q <= rcnt_q + RW'(1);
                    end
                    if (svalid && rcnt_q == RW'(DATA_WIDTH - 1)) begin
                        drdata_q <= rbuf_d;
                        ddone_q  <= 1'b1;
                        mbreq_q  <= 1'b0;
                        dready_q <= 1'b1;
                        state_q  <= ST_DONE;
                    end else if (ssplit) begin
                        mbreq_q <= 1'b0;
                        state_q <= ST_SPLIT;
                    end
                end
                ST_SPLIT: if (split_grant) begin
                    mbreq_q <= 1'b1;
                    state_q <= ST_RDATA;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign drdata = drdata_q;
    assign dready = dready_q;
    assign ddone  = ddone_q;
    assign derr   = derr_q;
    assign mbreq  = mbreq_q;
    assign mvalid = mvalid_q;

endmodule

// File: tb/tb_master_port.sv
// Scoreboard bench for master_port: the stimulus side pushes the expected
// serial frame and completion, independent monitors pop and compare.
module tb_master_port;

    localparam int AW  = 16;
    localparam int DW  = 4;
    localparam int DAW = 8;
    localparam int TO  = 4;

    logic clk = 1'b0;
    logic rstn;
    logic dvalid = 0, dmode = 0;
    logic [AW-1:0] daddr = '0;
    logic [DAW-1:0] dwdata = '0;
    logic [DAW-1:0] drdata;
    logic dready, ddone, derr, mbreq, mwdata, mvalid;
    logic mgrant = 0, ack = 0, mrdata = 0, svalid = 0, ssplit = 0, split_grant = 0;

    master_port #(.ADDR_WIDTH(AW), .DEVICE_ADDR_WIDTH(DW), .DATA_WIDTH(DAW), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .dvalid(dvalid), .dmode(dmode), .daddr(daddr), .dwdata(dwdata),
        .drdata(drdata), .dready(dready), .ddone(ddone), .derr(derr), .mbreq(mbreq),
        .mgrant(mgrant), .mwdata(mwdata), .mvalid(mvalid), .ack(ack), .mrdata(mrdata),
        .svalid(svalid), .ssplit(ssplit), .split_grant(split_grant)
    );

    always #5 clk = ~clk;

    typedef struct { logic err; logic [DAW-1:0] rd; } cmp_t;

    int tests = 0;
    int fails = 0;
    bit frame_q[$];
    cmp_t cmp_q[$];
    logic [DAW-1:0] last_rd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Serial frame monitor: every mvalid cycle must carry the next expected bit.
    always @(negedge clk) begin
        if (rstn && mvalid) begin
            if (frame_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL frame_extra: got bit %0d expected no bit", mwdata);
            end else begin
                chk("frame_bit", mwdata, frame_q.pop_front());
            end
        end
    end

    // Completion monitor: every ddone pulse matches the next expected result.
    always @(negedge clk) begin : mon_done
        cmp_t e;
        if (rstn && ddone) begin
            if (cmp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL done_extra: got ddone=1 expected none");
            end else begin
                e = cmp_q.pop_front();
                chk("derr", derr, e.err);
                chk("drdata", drdata, e.rd);
                chk("done_mbreq", mbreq, 0);
                chk("done_dready", dready, 1);
            end
        end
    end

    function automatic logic cur(input int w);
        case (w)
            0: return mvalid;
            1: return ddone;
            default: return dready;
        endcase
    endfunction

    task automatic wait_lvl(input logic lvl, input int which, input string name);
        int n;
        n = 0;
        while (cur(which) !== lvl && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n == 300) begin
            tests++; fails++;
            $display("FAIL timeout_%s: got no event expected level %0d", name, lvl);
        end
    endtask

    // Reference model: a frame is device bits, then (if acked) mode, memory
    // address and, for writes, data, each field LSB-first.
    task automatic push_model(input logic mode, input logic [AW-1:0] addr, input logic [DAW-1:0] wd,
                              input logic [DAW-1:0] rd, input logic ack_ok);
        cmp_t e;
        for (int i = 0; i < DW; i++) frame_q.push_back(addr[AW-DW+i]);
        if (ack_ok) begin
            frame_q.push_back(mode);
            for (int i = 0; i < AW-DW; i++) frame_q.push_back(addr[i]);
            if (mode) for (int i = 0; i < DAW; i++) frame_q.push_back(wd[i]);
            else last_rd = rd;
        end
        e.err = !ack_ok;
        e.rd  = last_rd;
        cmp_q.push_back(e);
    endtask

    task automatic txn(input logic mode, input logic [AW-1:0] addr, input logic [DAW-1:0] wd,
                       input logic [DAW-1:0] rd, input int gdly, input int ackdly,
                       input int split_at, input int split_wait, input logic [DAW-1:0] gapmask);
        logic ack_ok;
        int n;
        ack_ok = (ackdly >= 0);
        wait_lvl(1'b1, 2, "dready");
        push_model(mode, addr, wd, rd, ack_ok);
        dvalid = 1; dmode = mode; daddr = addr; dwdata = wd;
        @(negedge clk);
        dvalid = 0;
        chk("busy_dready", dready, 0);
        chk("req_mbreq", mbreq, 1);
        for (int i = 0; i < gdly; i++) begin
            dvalid = 1; dmode = 1'($urandom); daddr = AW'($urandom); dwdata = DAW'($urandom);
            @(negedge clk);
            chk("pre_grant_mvalid", mvalid, 0);
            chk("pre_grant_mbreq", mbreq, 1);
        end
        dvalid = 0;
        mgrant = 1;
        wait_lvl(1'b1, 0, "dev_start");
        wait_lvl(1'b0, 0, "dev_end");
        if (ack_ok) begin
            repeat (ackdly) @(negedge clk);
            ack = 1;
            @(negedge clk);
            ack = 0;
            wait_lvl(1'b0, 0, "frame_end");
            if (!mode) begin
                for (int i = 0; i < DAW; i++) begin
                    if (i == split_at) begin
                        ssplit = 1;
                        @(negedge clk);
                        ssplit = 0;
                        for (int j = 0; j < split_wait; j++) begin
                            chk("split_mbreq", mbreq, 0);
                            chk("split_mvalid", mvalid, 0);
                            @(negedge clk);
                        end
                        split_grant = 1;
                        @(negedge clk);
                        split_grant = 0;
                        chk("resume_mbreq", mbreq, 1);
                    end
                    if (gapmask[i]) @(negedge clk);
                    svalid = 1; mrdata = rd[i];
                    @(negedge clk);
                    svalid = 0; mrdata = 0;
                end
            end
            wait_lvl(1'b1, 1, "ddone");
        end else begin
            n = 0;
            while (!ddone && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("timeout_cycles", n, TO);
        end
        mgrant = 0;
        @(negedge clk);
        @(negedge clk);
        chk("frame_drained", frame_q.size(), 0);
        chk("done_drained", cmp_q.size(), 0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_mvalid"}, mvalid, 0);
        chk({tag, "_mwdata"}, mwdata, 0);
        chk({tag, "_mbreq"}, mbreq, 0);
        chk({tag, "_ddone"}, ddone, 0);
        chk({tag, "_derr"}, derr, 0);
        chk({tag, "_dready"}, dready, 1);
        chk({tag, "_drdata"}, drdata, 0);
    endtask

    // Write cut off by reset a few cycles into the slave frame.
    task automatic reset_mid_sframe();
        wait_lvl(1'b1, 2, "dready");
        push_model(1'b1, 16'h1234, 8'h5A, '0, 1'b1);
        dvalid = 1; dmode = 1; daddr = 16'h1234; dwdata = 8'h5A;
        @(negedge clk);
        dvalid = 0;
        mgrant = 1;
        wait_lvl(1'b1, 0, "rst_dev_start");
        wait_lvl(1'b0, 0, "rst_dev_end");
        ack = 1;
        @(negedge clk);
        ack = 0;
        repeat (5) @(negedge clk);
        chk("pre_rst_mvalid", mvalid, 1);
        #3 rstn = 0;
        #1 reset_checks("midrst");
        frame_q.delete();
        cmp_q.delete();
        last_rd = '0;
        mgrant = 0;
        @(negedge clk);
        rstn = 1;
        @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] dev;
        logic m;
        int sp;
        rstn = 1;
        #2 rstn = 0;
        repeat (2) @(negedge clk);
        reset_checks("rst");
        rstn = 1;
        @(negedge clk);

        txn(1, 16'h1234, 8'hA5, 8'h00, 0, 0, -1, 0, 8'h00);
        txn(0, 16'h2010, 8'h00, 8'h3C, 0, 0, -1, 0, 8'b0010_0100);
        txn(1, 16'h3055, 8'h11, 8'h00, 0, -1, -1, 0, 8'h00);
        txn(0, 16'h1ABC, 8'h00, 8'h96, 2, 1, 3, 20, 8'h00);
        txn(1, 16'h2F0F, 8'h5A, 8'h00, 10, TO-1, -1, 0, 8'h00);
        reset_mid_sframe();
        txn(0, 16'h0777, 8'h00, 8'hC3, 1, 0, -1, 0, 8'h81);

        for (int t = 0; t < 20; t++) begin
            dev = DW'($urandom_range(0, 15));
            m   = 1'($urandom);
            sp  = (!m && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, DAW-1)) : -1;
            txn(m, {dev, 12'($urandom)}, DAW'($urandom), DAW'($urandom),
                $urandom_range(0, 4), (dev == 4'd3) ? -1 : int'($urandom_range(0, TO-1)),
                sp, $urandom_range(1, 6), DAW'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
